fetch_decode_ctrl: RTL and testbench

- Multi-cycle instruction fetch/decode controller for the 8-bit, two-register CPU.
- Sits directly upstream of the register file. Owns the program counter and fetches 8-bit instructions from instruction memory.
- Decodes each instruction into the register file's controls: rd, rs, imm, immSelect, regSelect. Also drives the ALU opcode.
- Sequences each instruction through FETCH, DECODE, EXECUTE and WRITEBACK.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/instr_decoder.sv | 62 ++++++
 rtl/fetch_decode_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_decode_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings: opcodes, ALU ops, controller states, instruction fields
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LI   = 4'h6;
    localparam logic [3:0] OP_BNZ  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    // Instruction field positions
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int RD_BIT  = 3;
    localparam int RS_BIT  = 2;
    localparam int IMM_MSB = 2;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational decode of the instruction register into datapath controls
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] ir_i,
    output logic       rd_o,
    output logic       rs_o,
    output logic [2:0] imm_o,
    output logic       imm_sel_o,
    output logic [2:0] alu_op_o,
    output logic       writes_rd_o,
    output logic       is_branch_o,
    output logic       is_halt_o,
    output logic       is_illegal_o
);

    // Field extraction is unconditional; the opcode only selects the control bits
    always_comb begin
        rd_o         = ir_i[RD_BIT];
        rs_o         = ir_i[RS_BIT];
        imm_o        = ir_i[IMM_MSB:IMM_LSB];
        imm_sel_o    = 1'b0;
        alu_op_o     = ALU_PASS;
        writes_rd_o  = 1'b0;
        is_branch_o  = 1'b0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        case (ir_i[OPC_MSB:OPC_LSB])
            OP_NOP: ;
            OP_ADD: begin
                alu_op_o    = ALU_ADD;
                writes_rd_o = 1'b1;
            end
            OP_SUB: begin
                alu_op_o    = ALU_SUB;
                writes_rd_o = 1'b1;
            end
            OP_AND: begin
                alu_op_o    = ALU_AND;
                writes_rd_o = 1'b1;
            end
            OP_OR: begin
                alu_op_o    = ALU_OR;
                writes_rd_o = 1'b1;
            end
            OP_ADDI: begin
                alu_op_o    = ALU_ADD;
                imm_sel_o   = 1'b1;
                writes_rd_o = 1'b1;
            end
            OP_LI: begin
                alu_op_o    = ALU_PASS;
                imm_sel_o   = 1'b1;
                writes_rd_o = 1'b1;
            end
            OP_BNZ:  is_branch_o  = 1'b1;
            OP_HALT: is_halt_o    = 1'b1;
            default: is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// rtl/fetch_decode_ctrl.sv - multi-cycle fetch/decode controller; ILLEGAL_TRAP_EN enables the illegal-opcode trap
module fetch_decode_ctrl
    import cpu_pkg::*;
#(
    parameter int          PC_W     = 5,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            CLK,
    input  logic            RST,
    output logic [PC_W-1:0] instr_addr,
    output logic            instr_req,
    input  logic            instr_valid,
    input  logic [7:0]      instr_data,
    input  logic [7:0]      rd_data,
    output logic            rd,
    output logic            rs,
    output logic [2:0]      imm,
    output logic            immSelect,
    output logic            regSelect,
    output logic [2:0]      alu_op,
    output logic            halted,
    output logic            illegal
);

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [7:0]      ir_q;
    logic            instr_req_q;
    logic            reg_select_q;
    logic            halted_q;
    logic            illegal_q;

    logic            dec_writes_rd;
    logic            dec_branch;
    logic            dec_halt;
    logic            dec_illegal;
    logic [PC_W-1:0] imm_sext;

    // rd/rs/imm/immSelect/alu_op come straight from the IR so they stay stable until the next fetch
    instr_decoder u_decoder (
        .ir_i         (ir_q),
        .rd_o         (rd),
        .rs_o         (rs),
        .imm_o        (imm),
        .imm_sel_o    (immSelect),
        .alu_op_o     (alu_op),
        .writes_rd_o  (dec_writes_rd),
        .is_branch_o  (dec_branch),
        .is_halt_o    (dec_halt),
        .is_illegal_o (dec_illegal)
    );

    assign imm_sext = {{(PC_W-3){imm[2]}}, imm};

    // Next sequential PC, or the taken-branch target; wraps modulo 2^PC_W
    always_comb begin
        pc_d = pc_q + PC_ONE;
        if (dec_branch && (rd_data != 8'd0)) begin
            pc_d = pc_q + PC_ONE + imm_sext;
        end
    end

    // Controller FSM: state, PC, IR and registered handshake/status outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC_V;
            ir_q         <= 8'd0;
            instr_req_q  <= 1'b0;
            reg_select_q <= 1'b0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            reg_select_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    // First FETCH after reset only raises the request; data is taken once it is up
                    if (!instr_req_q) begin
                        instr_req_q <= 1'b1;
                    end else if (instr_valid) begin
                        ir_q        <= instr_data;
                        instr_req_q <= 1'b0;
                        state_q     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_q <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (dec_halt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    end else if (dec_illegal) begin
                        state_q   <= ST_HALT;
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
`endif
                    end else if (dec_writes_rd) begin
                        state_q      <= ST_WRITEBACK;
                        reg_select_q <= 1'b1;
                    end else begin
                        state_q     <= ST_FETCH;
                        instr_req_q <= 1'b1;
                        pc_q        <= pc_d;
                    end
                end
                ST_WRITEBACK: begin
                    state_q     <= ST_FETCH;
                    instr_req_q <= 1'b1;
                    pc_q        <= pc_d;
                end
                ST_HALT: ;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

`ifndef ILLEGAL_TRAP_EN
    // Without the trap, illegal opcodes fall through the NOP path and the decode flag is not needed
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
`endif

    assign instr_addr = pc_q;
    assign instr_req  = instr_req_q;
    // A reset arriving in WRITEBACK suppresses the write strobe so the register file never commits
    assign regSelect  = reg_select_q & ~RST;
    assign halted     = halted_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb/tb_fetch_decode_ctrl.sv - scoreboard bench for fetch_decode_ctrl
module tb_fetch_decode_ctrl;

    localparam int PC_W     = 5;
    localparam int RESET_PC = 0;

    logic            CLK = 1'b0;
    logic            RST;
    logic [PC_W-1:0] instr_addr;
    logic            instr_req;
    logic            instr_valid;
    logic [7:0]      instr_data;
    logic [7:0]      rd_data;
    logic            rd;
    logic            rs;
    logic [2:0]      imm;
    logic            immSelect;
    logic            regSelect;
    logic [2:0]      alu_op;
    logic            halted;
    logic            illegal;

    always #5 CLK = ~CLK;

    fetch_decode_ctrl #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .instr_addr  (instr_addr),
        .instr_req   (instr_req),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .rd_data     (rd_data),
        .rd          (rd),
        .rs          (rs),
        .imm         (imm),
        .immSelect   (immSelect),
        .regSelect   (regSelect),
        .alu_op      (alu_op),
        .halted      (halted),
        .illegal     (illegal)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] mem [0:31];
    logic [8:0] wq[$];
    int         exp_pc;
    int         halt_pc;
    bit         exp_halt;
    bit         exp_ill;
    int         prev_acc;
    int         prev_lat;
    int         cycle = 0;
    logic [7:0] last_ir;

    // {rd, rs, imm, immSelect} the decoder must present for instruction d
    function automatic logic [5:0] stat_fields(input logic [7:0] d);
        logic isel;
        isel = (d[7:4] == 4'h5) || (d[7:4] == 4'h6);
        return {d[3], d[2], d[2:0], isel};
    endfunction

    // Full write-event record {rd, rs, imm, immSelect, alu_op}
    function automatic logic [8:0] wr_fields(input logic [7:0] d);
        logic [2:0] alu;
        case (d[7:4])
            4'h1:    alu = 3'd1;
            4'h2:    alu = 3'd2;
            4'h3:    alu = 3'd3;
            4'h4:    alu = 3'd4;
            4'h5:    alu = 3'd1;
            default: alu = 3'd0;
        endcase
        return {stat_fields(d), alu};
    endfunction

    // Reference behaviour of one instruction fetched from exp_pc
    task automatic model(input logic [7:0] d);
        int next;
        int s;
        next     = exp_pc + 1;
        prev_lat = 3;
        case (d[7:4])
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                wq.push_back(wr_fields(d));
                prev_lat = 4;
            end
            4'h7: begin
                s = d[2] ? int'(d[2:0]) - 8 : int'(d[2:0]);
                if (rd_data != 8'd0) next = exp_pc + 1 + s;
            end
            4'hF: begin
                exp_halt = 1'b1;
                halt_pc  = exp_pc;
                exp_ill  = 1'b0;
            end
            4'h0: ;
            default: begin
`ifdef ILLEGAL_TRAP_EN
                exp_halt = 1'b1;
                halt_pc  = exp_pc;
                exp_ill  = 1'b1;
`endif
            end
        endcase
        exp_pc = next & ((1 << PC_W) - 1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    // Reset with instr_valid high so the coincident data must be discarded
    task automatic do_reset();
        RST         = 1'b1;
        instr_valid = 1'b1;
        instr_data  = 8'h65;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("rst_outputs", 32'({rd, rs, imm, immSelect, regSelect, alu_op, halted, illegal, instr_req}), 32'd0);
        check("rst_pc", 32'(instr_addr), 32'(RESET_PC));
        RST         = 1'b0;
        instr_valid = 1'b0;
        @(posedge CLK); #1;
        check("req_after_rst", 32'(instr_req), 32'd1);
        wq.delete();
        exp_pc   = RESET_PC;
        exp_halt = 1'b0;
        exp_ill  = 1'b0;
        prev_acc = -1;
        prev_lat = 0;
        last_ir  = 8'h00;
    endtask

    task automatic run_prog(input int n_fetch, input int waits);
        int         fetched;
        int         wait_left;
        bit         done;
        logic [8:0] wf;
        logic [5:0] sf;
        fetched   = 0;
        wait_left = waits;
        done      = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(posedge CLK); #1;
            cycle++;
            instr_valid = 1'b0;
            if (regSelect) begin
                if (wq.size() == 0) begin
                    check("spurious_write", 32'd1, 32'd0);
                end else begin
                    wf = wq.pop_front();
                    check("write_fields", 32'({rd, rs, imm, immSelect, alu_op}), 32'(wf));
                end
            end
            if (halted) begin
                check("halt_expected", 32'(exp_halt), 32'd1);
                check("halt_pc", 32'(instr_addr), 32'(halt_pc));
                check("illegal_flag", 32'(illegal), 32'(exp_ill));
                for (int k = 0; k < 6; k++) begin
                    @(posedge CLK); #1;
                    instr_valid = 1'b1;
                    instr_data  = 8'($urandom);
                    check("halt_hold", 32'({halted, instr_req, regSelect, instr_addr}),
                          32'({1'b1, 1'b0, 1'b0, 5'(halt_pc)}));
                end
                instr_valid = 1'b0;
                done = 1'b1;
            end else if (instr_req) begin
                if (exp_halt) begin
                    check("req_after_halt", 32'd1, 32'd0);
                    done = 1'b1;
                end else if (wait_left > 0) begin
                    wait_left--;
                    sf = stat_fields(last_ir);
                    check("wait_hold", 32'({rd, rs, imm, immSelect, regSelect}), 32'({sf, 1'b0}));
                end else if (fetched == n_fetch) begin
                    done = 1'b1;
                end else begin
                    check("fetch_addr", 32'(instr_addr), 32'(exp_pc));
                    if (prev_acc >= 0) check("latency", 32'(cycle - prev_acc), 32'(prev_lat + waits));
                    prev_acc    = cycle;
                    instr_valid = 1'b1;
                    instr_data  = mem[instr_addr];
                    last_ir     = mem[instr_addr];
                    model(last_ir);
                    fetched++;
                    wait_left = waits;
                end
            end else begin
                instr_valid = 1'($urandom_range(0, 1));
                instr_data  = 8'($urandom);
            end
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        check("write_drain", 32'(wq.size()), 32'd0);
        instr_valid = 1'b0;
    endtask

    initial begin
        RST         = 1'b1;
        instr_valid = 1'b0;
        instr_data  = 8'h00;
        rd_data     = 8'h00;

        // LI, ADD, ADDI, SUB, then BNZ -2 taken back to 3
        clear_mem();
        mem[0] = 8'h65;
        mem[1] = 8'h11;
        mem[2] = 8'h5A;
        mem[3] = 8'h2C;
        mem[4] = 8'h7E;
        rd_data = 8'h03;
        do_reset();
        run_prog(9, 0);

        // AND, OR, NOPs, BNZ not taken, illegal, HALT; six wait cycles per fetch
        clear_mem();
        mem[0] = 8'h38;
        mem[1] = 8'h44;
        mem[4] = 8'h7E;
        mem[5] = 8'h90;
        mem[6] = 8'hF0;
        rd_data = 8'h00;
        do_reset();
        run_prog(20, 6);

        // PC wrap: BNZ -4 at 0 lands on 29, NOP at 31 wraps to 0
        clear_mem();
        mem[0] = 8'h7C;
        rd_data = 8'h01;
        do_reset();
        run_prog(8, 0);

        // Reset asserted while in WRITEBACK
        clear_mem();
        do_reset();
        instr_valid = 1'b1;
        instr_data  = 8'h65;
        @(posedge CLK); #1;
        instr_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("wb_reached", 32'(regSelect), 32'd1);
        RST = 1'b1;
        #1;
        check("wb_abort", 32'(regSelect), 32'd0);
        @(posedge CLK); #1;
        check("wb_rst_outputs", 32'({rd, rs, imm, immSelect, regSelect, alu_op, halted, illegal}), 32'd0);
        check("wb_rst_pc", 32'(instr_addr), 32'(RESET_PC));
        RST = 1'b0;

        // HALT as the very first instruction
        clear_mem();
        mem[0] = 8'hF0;
        do_reset();
        run_prog(5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
